// File: rtl/sha256_ctrl_pkg.sv
// Shared constants and FSM state type for the SHA256 control/digest path.
package sha256_ctrl_pkg;

  localparam int DIGEST_W   = 256;
  localparam int WR_COUNT_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/digest_rr_pick.sv
// Combinational priority picker: scans requests starting at 'start' and
// wrapping, returns a one-hot grant plus the encoded winner index.
module digest_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // First asserted request at or after 'start' (modulo N) wins.
  always_comb begin
    int j;
    logic [IW-1:0] jj;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!any && req[jj]) begin
        any       = 1'b1;
        grant[jj] = 1'b1;
        idx       = jj;
      end
    end
  end

endmodule

// File: rtl/digest_write_arbiter.sv
// Arbitrates several SHA256 cores onto the single digest memory: grants one
// finished digest, issues a one-cycle write, then holds it valid until acked.
// Build option: DIGEST_ARB_RR_EN selects round-robin arbitration; when it is
// not defined the lowest requesting index always wins.
module digest_write_arbiter
  import sha256_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DIGEST_W-1:0] req_digest,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        mem_write_en,
  output logic [DIGEST_W-1:0]         mem_digest_in,
  output logic                        out_valid,
  output logic [ID_W-1:0]             out_id,
  input  logic                        out_ack,
  output logic [WR_COUNT_W-1:0]       wr_count
);

  arb_state_e          state, state_nxt;
  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;
  logic [ID_W-1:0]     pick_start;
  logic                xfer;

  digest_rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
    .req   (req_valid),
    .start (pick_start),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef DIGEST_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr;

  // Pointer moves one past the last winner so every core gets a turn.
  always_ff @(posedge CLK) begin
    if (!RST)      rr_ptr <= '0;
    else if (xfer) rr_ptr <= (pick_idx == ID_W'(NUM_REQ-1)) ? '0 : pick_idx + ID_W'(1);
  end

  assign pick_start = rr_ptr;
`else
  assign pick_start = '0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and per-state outputs. No grant is offered while reset is
  // held, since the reset edge would discard the transfer anyway.
  always_comb begin
    state_nxt    = state;
    req_ready    = '0;
    mem_write_en = 1'b0;
    out_valid    = 1'b0;
    xfer         = 1'b0;
    case (state)
      IDLE: begin
        if (RST) begin
          req_ready = pick_grant;
          xfer      = pick_any;
        end
        if (xfer) state_nxt = WRITE;
      end
      WRITE: begin
        mem_write_en = 1'b1;
        state_nxt    = FULL;
      end
      FULL: begin
        out_valid = 1'b1;
        if (out_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the winner's digest and index on the transfer edge only.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      mem_digest_in <= '0;
      out_id        <= '0;
    end else if (xfer) begin
      mem_digest_in <= req_digest[pick_idx*DIGEST_W +: DIGEST_W];
      out_id        <= pick_idx;
    end
  end

  // Count completed memory writes; wraps naturally at 2^32.
  always_ff @(posedge CLK) begin
    if (!RST)                wr_count <= '0;
    else if (state == WRITE) wr_count <= wr_count + 1'b1;
  end

endmodule

// File: doc/digest_write_arbiter.md
# digest_write_arbiter

Shares the single 256-bit digest memory (`mem_save_digest`) between several SHA256 cores. It accepts a finished digest from one requester at a time and sequences the memory write. It then holds the stored digest valid until the downstream consumer acknowledges it. It sits between the SHA256 core array and the digest memory / result readout logic.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesting SHA256 cores; legal range 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester index.

Ports:
- `CLK`, input, 1: single clock, rising edge.
- `RST`, input, 1: reset, synchronous, active-low. All state is cleared on a rising `CLK` edge while `RST==0`.
- `req_valid`, input, `NUM_REQ`: bit i set means core i has a digest pending.
- `req_digest`, input, `NUM_REQ*256`: digest of core i is at bits `[i*256 +: 256]`.
- `req_ready`, output, `NUM_REQ`: one-hot grant; a transfer occurs on an edge where `req_valid[i] & req_ready[i]`.
- `mem_write_en`, output, 1: write strobe to the digest memory.
- `mem_digest_in`, output, 256: write data to the digest memory.
- `out_valid`, output, 1: the digest memory holds an unconsumed digest.
- `out_id`, output, `ID_W`: index of the core whose digest is stored.
- `out_ack`, input, 1: the consumer has read the digest; sampled only while `out_valid==1`.
- `wr_count`, output, 32: total digests written since reset.

## Operation
- FSM states: IDLE, WRITE, FULL.
- **IDLE**
  - `req_ready` is the combinational one-hot grant of the winner among asserted `req_valid` bits; it is all-zero when no request is pending.
  - On a transfer, the winner's digest is latched into `mem_digest_in`, the winner index is latched into `out_id`, and the FSM moves to WRITE.
- **WRITE**
  - `mem_write_en=1` for exactly one cycle; `req_ready=0`.
  - `wr_count` increments and wraps from 0xFFFFFFFF to 0.
  - The FSM moves to FULL.
- **FULL**
  - `out_valid=1`; `req_ready=0`.
  - On an edge with `out_ack=1`, the FSM moves to IDLE.
  - `out_ack` outside FULL is ignored.
- Requesters must hold `req_valid` and `req_digest` stable until granted; retraction is undefined.
- `mem_digest_in` and `out_id` keep their last values outside the transfer edge.
- Simultaneous requests are resolved per Configuration; only one grant per IDLE cycle.
- A request arriving during WRITE or FULL waits; no grant is issued and nothing is lost.
- Reset mid-operation: the FSM returns to IDLE, any in-flight grant is dropped, and the requester must re-present. The digest memory has its own reset.

## Timing
- Reset values: `req_ready=0`, `mem_write_en=0`, `mem_digest_in=0`, `out_valid=0`, `out_id=0`, `wr_count=0`, round-robin pointer = 0.
- Transfer at edge T:
  - `mem_write_en` is high in cycle T..T+1.
  - The memory is updated at edge T+1.
  - `out_valid` rises after edge T+1.
- `out_ack` may be high in the first FULL cycle; `out_valid` then drops after the next edge.
- Minimum throughput: one digest per 3 cycles (IDLE, WRITE, FULL with immediate ack).
- `req_ready` is combinational from `req_valid` and state only; it has no path from `out_ack`.

## Configuration
- Macro: `DIGEST_ARB_RR_EN`.
- Defined: round-robin arbitration.
  - The search starts at the pointer.
  - On each transfer the pointer becomes (granted index + 1) mod `NUM_REQ`.
- Undefined: fixed priority, with the lowest index winning; the pointer logic is removed.

## Structure
- Shared package `sha256_ctrl_pkg`:
  - `DIGEST_W = 256`
  - FSM state enum (IDLE, WRITE, FULL)
  - `WR_COUNT_W = 32`
- One sub-module, `digest_rr_pick`: a combinational priority picker with a start-index input (tied to 0 when `DIGEST_ARB_RR_EN` is undefined). It outputs a one-hot grant and an encoded index.
- FSM, capture registers and counter live in the top module.

## Test plan
- **Reset:** hold `RST=0` 3 cycles with `req_valid=4'b1111` → all outputs 0, `req_ready=0`.
- **Single request:** `req_valid=4'b0100`, digest 0xA5…A5 → `req_ready=4'b0100` in IDLE; `mem_write_en` 1 cycle with data 0xA5…A5; `out_valid=1`, `out_id=2`, `wr_count=1`.
- **Contention, RR defined:** `req_valid=4'b1111` held, `out_ack` tied 1 → grant order 0,1,2,3,0; one grant every 3 cycles.
- **Contention, RR undefined:** same stimulus with core i dropping valid after its grant → grant order 0,1,2,3.
- **Backpressure:** hold `out_ack=0` 10 cycles in FULL with core 1 requesting → no `req_ready`, no `mem_write_en`, `out_id` stable; after ack, core 1 is granted on the following cycle.
- **Reset mid-WRITE:** assert `RST=0` during WRITE → `mem_write_en=0` and `wr_count=0` after the edge; FSM in IDLE.
